// File: rtl/sub_div.sv
// sub_div: unsigned restoring divider by repeated subtraction.
// Ports: CLK, ASYNCRESETN, START, I0/I1 (dividend/divisor) in;
//        BUSY, DONE, Q, R, DIVZERO out. Optional ABORT input
//        is present only when SUB_DIV_ABORT_EN is defined.
module sub_div #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic             START,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
`ifdef SUB_DIV_ABORT_EN
    input  logic             ABORT,
`endif
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             DIVZERO
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             dz_q, dz_d;

    logic [WIDTH:0]   diff;
    logic             borrow;
    logic             abort_w;

    // One extra bit catches the borrow, so R never wraps.
    assign diff   = {1'b0, r_q} - {1'b0, d_q};
    assign borrow = diff[WIDTH];

`ifdef SUB_DIV_ABORT_EN
    assign abort_w = ABORT;
`else
    assign abort_w = 1'b0;
`endif

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            d_q     <= d_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        d_d     = d_q;
        dz_d    = dz_q;
        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    r_d = I0;
                    if (I1 == '0) begin
                        q_d     = ONES;
                        dz_d    = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        q_d     = '0;
                        d_d     = I1;
                        dz_d    = 1'b0;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                // Abort wins over both subtract and finish.
                if (abort_w) begin
                    state_d = S_IDLE;
                end else if (!borrow) begin
                    r_d = diff[WIDTH-1:0];
                    q_d = q_q + ONE;
                end else begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign BUSY    = (state_q == S_RUN);
    assign DONE    = (state_q == S_FIN);
    assign Q       = q_q;
    assign R       = r_q;
    assign DIVZERO = dz_q;

endmodule

// File: tb/tb_sub_div.sv
// tb_sub_div: directed vector table plus hand sequences
// for held START, ignored START, async reset and abort.
module tb_sub_div;

    localparam int W = 4;

    logic         CLK;
    logic         ASYNCRESETN;
    logic         START;
    logic [W-1:0] I0;
    logic [W-1:0] I1;
`ifdef SUB_DIV_ABORT_EN
    logic         ABORT;
`endif
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] Q;
    logic [W-1:0] R;
    logic         DIVZERO;

    int n_vec;
    int n_err;

    sub_div #(.WIDTH(W)) dut (
        .CLK(CLK),
        .ASYNCRESETN(ASYNCRESETN),
        .START(START),
        .I0(I0),
        .I1(I1),
`ifdef SUB_DIV_ABORT_EN
        .ABORT(ABORT),
`endif
        .BUSY(BUSY),
        .DONE(DONE),
        .Q(Q),
        .R(R),
        .DIVZERO(DIVZERO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         edz;
        int           lat;
        int           busy;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Entered and left at posedge+1.
    task automatic run_div(input logic [W-1:0] a,
                           input logic [W-1:0] b,
                           output logic [31:0] q,
                           output logic [31:0] r,
                           output logic [31:0] dz,
                           output int lat,
                           output int bcnt);
        START = 1'b1;
        I0 = a;
        I1 = b;
        @(posedge CLK);
        #1;
        START = 1'b0;
        I0 = W'($urandom);
        I1 = W'($urandom);
        lat = 1;
        bcnt = 0;
        while (!DONE && lat < 40) begin
            if (BUSY) bcnt++;
            @(posedge CLK);
            #1;
            lat++;
        end
        if (!DONE) lat = 999;
        q = 32'(Q);
        r = 32'(R);
        dz = 32'(DIVZERO);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [31:0] q, r, dz;
        int lat, bc, cnt;
        logic seen;

        n_vec = 0;
        n_err = 0;
        vt[0] = '{4'd13, 4'd4,  4'd3,  4'd1, 1'b0, 5,  4};
        vt[1] = '{4'd5,  4'd0,  4'd15, 4'd5, 1'b1, 1,  0};
        vt[2] = '{4'd3,  4'd7,  4'd0,  4'd3, 1'b0, 2,  1};
        vt[3] = '{4'd15, 4'd1,  4'd15, 4'd0, 1'b0, 17, 16};
        vt[4] = '{4'd9,  4'd3,  4'd3,  4'd0, 1'b0, 5,  4};
        vt[5] = '{4'd0,  4'd5,  4'd0,  4'd0, 1'b0, 2,  1};
        vt[6] = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0, 3,  2};
        vt[7] = '{4'd0,  4'd0,  4'd15, 4'd0, 1'b1, 1,  0};

        START = 1'b0;
        I0 = '0;
        I1 = '0;
`ifdef SUB_DIV_ABORT_EN
        ABORT = 1'b0;
`endif
        ASYNCRESETN = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_done", 32'(DONE), 0);
        chk("rst_q", 32'(Q), 0);
        chk("rst_r", 32'(R), 0);
        chk("rst_dz", 32'(DIVZERO), 0);
        #3;
        ASYNCRESETN = 1'b1;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 8; i++) begin
            run_div(vt[i].a, vt[i].b, q, r, dz, lat, bc);
            chk($sformatf("v%0d_q", i), q, 32'(vt[i].eq));
            chk($sformatf("v%0d_r", i), r, 32'(vt[i].er));
            chk($sformatf("v%0d_dz", i), dz, 32'(vt[i].edz));
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vt[i].lat));
            chk($sformatf("v%0d_busy", i), 32'(bc), 32'(vt[i].busy));
        end

        // Results hold in IDLE.
        repeat (3) @(posedge CLK);
        #1;
        chk("hold_q", 32'(Q), 15);
        chk("hold_r", 32'(R), 0);
        chk("hold_dz", 32'(DIVZERO), 1);

        // START held high: back-to-back 8/2.
        START = 1'b1;
        I0 = 4'd8;
        I1 = 4'd2;
        cnt = 0;
        while (!DONE && cnt < 40) begin
            @(posedge CLK);
            #1;
            cnt++;
        end
        chk("held1_lat", 32'(cnt), 6);
        chk("held1_q", 32'(Q), 4);
        chk("held1_r", 32'(R), 0);
        @(posedge CLK);
        #1;
        chk("held_gap_busy", 32'(BUSY), 0);
        chk("held_gap_done", 32'(DONE), 0);
        @(posedge CLK);
        #1;
        chk("held2_busy", 32'(BUSY), 1);
        cnt = 2;
        while (!DONE && cnt < 40) begin
            @(posedge CLK);
            #1;
            cnt++;
        end
        chk("held2_gap", 32'(cnt), 7);
        chk("held2_q", 32'(Q), 4);
        chk("held2_r", 32'(R), 0);
        START = 1'b0;
        @(posedge CLK);
        #1;

        // START during RUN is ignored.
        START = 1'b1;
        I0 = 4'd8;
        I1 = 4'd2;
        @(posedge CLK);
        #1;
        START = 1'b0;
        @(posedge CLK);
        #1;
        START = 1'b1;
        I0 = 4'd15;
        I1 = 4'd1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        cnt = 3;
        while (!DONE && cnt < 40) begin
            @(posedge CLK);
            #1;
            cnt++;
        end
        chk("ign_lat", 32'(cnt), 6);
        chk("ign_q", 32'(Q), 4);
        chk("ign_r", 32'(R), 0);
        repeat (2) @(posedge CLK);
        #1;
        chk("ign_noqueue", 32'(BUSY), 0);

        // Async reset mid-RUN, between edges.
        START = 1'b1;
        I0 = 4'd15;
        I1 = 4'd1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("pre_rst_busy", 32'(BUSY), 1);
        #2;
        ASYNCRESETN = 1'b0;
        #1;
        chk("arst_busy", 32'(BUSY), 0);
        chk("arst_done", 32'(DONE), 0);
        chk("arst_q", 32'(Q), 0);
        chk("arst_r", 32'(R), 0);
        chk("arst_dz", 32'(DIVZERO), 0);
        seen = 1'b0;
        repeat (2) begin
            @(posedge CLK);
            #1;
            if (DONE) seen = 1'b1;
        end
        #3;
        ASYNCRESETN = 1'b1;
        repeat (3) begin
            @(posedge CLK);
            #1;
            if (DONE) seen = 1'b1;
        end
        chk("arst_nodone", 32'(seen), 0);
        run_div(4'd9, 4'd3, q, r, dz, lat, bc);
        chk("post_rst_q", q, 3);
        chk("post_rst_r", r, 0);
        chk("post_rst_lat", 32'(lat), 5);

`ifdef SUB_DIV_ABORT_EN
        // 15/1 aborted after the third RUN edge.
        START = 1'b1;
        I0 = 4'd15;
        I1 = 4'd1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        ABORT = 1'b1;
        @(posedge CLK);
        #1;
        ABORT = 1'b0;
        chk("abt_busy", 32'(BUSY), 0);
        chk("abt_done", 32'(DONE), 0);
        chk("abt_q", 32'(Q), 3);
        chk("abt_r", 32'(R), 12);
        seen = 1'b0;
        repeat (4) begin
            @(posedge CLK);
            #1;
            if (DONE || BUSY) seen = 1'b1;
        end
        chk("abt_quiet", 32'(seen), 0);
        chk("abt_hold_q", 32'(Q), 3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sub_div.md
SUB_DIV -- requirements
Module: sub_div

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, setting the operand, quotient and remainder width in bits (legal range 2..16).
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port ASYNCRESETN, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port START, input, 1 bit: request to begin a division; sampled only in IDLE.
REQ-005 The block SHALL have port I0, input, WIDTH bits: unsigned dividend, captured with START.
REQ-006 The block SHALL have port I1, input, WIDTH bits: unsigned divisor, captured with START.
REQ-007 The block SHALL have port BUSY, output, 1 bit: high while in RUN.
REQ-008 The block SHALL have port DONE, output, 1 bit: one-cycle completion pulse.
REQ-009 The block SHALL have port Q, output, WIDTH bits: quotient.
REQ-010 The block SHALL have port R, output, WIDTH bits: remainder.
REQ-011 The block SHALL have port DIVZERO, output, 1 bit: set when the captured divisor was zero.

Function
REQ-012 The block SHALL implement a state machine with exactly three states: IDLE, RUN and FIN.
REQ-013 In IDLE with START=1 and I1!=0, the next edge SHALL perform: R<=I0, the divisor register <=I1, Q<=0, DIVZERO<=0, state<=RUN.
REQ-014 In IDLE with START=1 and I1==0, the next edge SHALL perform: Q<=all ones, R<=I0, DIVZERO<=1, state<=FIN.
REQ-015 In RUN, each edge SHALL do one of the following: if R>=divisor, then R<=R-divisor and Q<=Q+1, staying in RUN; otherwise state<=FIN with Q and R held.
REQ-016 The R>=divisor decision SHALL be the absence of borrow from a (WIDTH+1)-bit subtraction R-divisor.
REQ-017 R SHALL never wrap.
REQ-018 Q SHALL never overflow, since its maximum is 2^WIDTH-1 with divisor 1.
REQ-019 DONE SHALL be 1 exactly during the single cycle the machine is in FIN; FIN SHALL always go to IDLE on the next edge.
REQ-020 Latency SHALL be Q+2 edges from the START-sampling edge to DONE visible, counting that edge.
REQ-021 Divide-by-zero latency SHALL be 1 edge.
REQ-022 START asserted in RUN or FIN SHALL be ignored and not queued.
REQ-023 START held high continuously SHALL start a new division on the first IDLE cycle after FIN.
REQ-024 Q, R and DIVZERO SHALL hold their final values from FIN until the next accepted START.
REQ-025 I0 and I1 SHALL be don't-care outside the START-sampling cycle.
REQ-026 BUSY SHALL be 1 in RUN only.

Reset
REQ-027 ASYNCRESETN=0 SHALL immediately, without waiting for a clock edge, force state IDLE and Q=0, R=0, BUSY=0, DONE=0, DIVZERO=0, including when asserted mid-RUN or in FIN.
REQ-028 After deassertion, the first edge SHALL be able to accept START.

Configuration
REQ-029 The block SHALL support the macro SUB_DIV_ABORT_EN.
REQ-030 When SUB_DIV_ABORT_EN is defined, the block SHALL add a 1-bit input ABORT.
REQ-031 With SUB_DIV_ABORT_EN defined, ABORT=1 in RUN SHALL force state<=IDLE on the next edge with no DONE pulse and Q, R held at their current partial values.
REQ-032 ABORT SHALL have priority over the RUN-to-FIN transition.
REQ-033 ABORT SHALL have no effect in IDLE or FIN.
REQ-034 When SUB_DIV_ABORT_EN is undefined, the ABORT port SHALL NOT exist and behaviour SHALL be exactly REQ-012 to REQ-026.

Verification
REQ-035 The bench SHALL cover: WIDTH=4, I0=13, I1=4, START for 1 cycle -> BUSY for 4 cycles, DONE on the 5th edge, Q=3, R=1, DIVZERO=0.
REQ-036 The bench SHALL cover: I0=5, I1=0 -> DONE after 1 edge, Q=15, R=5, DIVZERO=1, BUSY never 1.
REQ-037 The bench SHALL cover: I0=3, I1=7 -> Q=0, R=3, DONE after 2 edges. Also I0=15, I1=1 -> Q=15, R=0, DONE after 17 edges.
REQ-038 The bench SHALL cover: START held high with I0=8, I1=2 -> Q=4, R=0 per DONE, with back-to-back divisions separated by exactly one IDLE cycle. A second START during RUN with different operands SHALL leave the result unchanged.
REQ-039 The bench SHALL cover: ASYNCRESETN pulsed low mid-RUN between clock edges -> all outputs 0 before the next edge, DONE never pulses, and a subsequent 9/3 gives Q=3, R=0.
REQ-040 With SUB_DIV_ABORT_EN defined, the bench SHALL cover: 15/1 with ABORT high for 1 cycle after the 3rd RUN edge -> IDLE, no DONE, Q=3, R=12 held.
